// File: rtl/store_buffer.sv
// Word-store write buffer between MEM stage and data memory: circular store FIFO,
// youngest-match load forwarding, and ownership of the data-memory port.
// Optional feature macro: STBUF_FWD_EN (load forwarding; otherwise matching loads stall).
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    output logic                   st_ready,
    input  logic                   ld_req,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_hit,
    output logic [DW-1:0]          ld_fwd_data,
    output logic                   ld_stall,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;
    logic          full;
    logic          push;
    logic          drain;
    logic          match;
`ifdef STBUF_FWD_EN
    logic [DW-1:0] match_data;
`endif

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign empty    = (head == tail);
    assign full     = (head[IW] != tail[IW]) && (head_idx == tail_idx);
    assign count    = tail - head;
    assign st_ready = !full;
    // A store offered while full is refused even if a drain frees a slot this cycle.
    assign push     = st_valid && !full;
    assign mem_we   = drain;

    // Walk occupied entries oldest to youngest so the last hit is the youngest match.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        match = 1'b0;
`ifdef STBUF_FWD_EN
        match_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) &&
                addr_mem[head_idx + IW'(i)][AW-1:2] == ld_addr[AW-1:2]) begin
                match = 1'b1;
`ifdef STBUF_FWD_EN
                match_data = data_mem[head_idx + IW'(i)];
`endif
            end
        end
    end

    // Port arbitration; reset gates every strobe regardless of ld_req.
    always_comb begin
        drain       = 1'b0;
        mem_re      = 1'b0;
        ld_hit      = 1'b0;
        ld_stall    = 1'b0;
        ld_fwd_data = '0;
        if (!reset) begin
            if (ld_req && match) begin
`ifdef STBUF_FWD_EN
                ld_hit      = 1'b1;
                ld_fwd_data = match_data;
`else
                ld_stall    = 1'b1;
`endif
                drain = 1'b1;
            end else if (ld_req && !full) begin
                mem_re = 1'b1;
            end else if (ld_req) begin
                ld_stall = 1'b1;
                drain    = 1'b1;
            end else begin
                drain = !empty;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_re) begin
            mem_addr = ld_addr;
        end else if (!empty) begin
            mem_addr = addr_mem[head_idx];
        end
        if (!empty) begin
            mem_wdata = data_mem[head_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_idx] <= st_addr;
            data_mem[tail_idx] <= st_data;
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-store write buffer between the MEM stage and the data memory. Stores are queued in a small circular FIFO and drained to memory one per cycle whenever the memory port is not needed by a load. Loads check the buffer first and are forwarded the youngest matching pending store. Only if nothing matches does a load go to memory. The block owns the data-memory port: address, write data, write enable and read enable.

## Interface
- DEPTH, 4: number of store entries; power of two, ≥2
- AW, 32: address width
- DW, 32: data width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- st_valid  in  1  store request from MEM stage
- st_addr  in  AW  store byte address; word-aligned (addr[1:0]=00)
- st_data  in  DW  store data
- st_ready  out  1  buffer accepts a store this cycle (= !full)
- ld_req  in  1  load request from MEM stage
- ld_addr  in  AW  load byte address; word-aligned
- ld_hit  out  1  load satisfied from buffer
- ld_fwd_data  out  DW  forwarded data; valid when ld_hit
- ld_stall  out  1  load not serviced this cycle; MEM stage must hold ld_req and ld_addr
- mem_addr  out  AW  data-memory address
- mem_wdata  out  DW  data-memory write data
- mem_we  out  1  data-memory write enable, one cycle per drained entry
- mem_re  out  1  data-memory read enable
- empty  out  1  no pending stores
- count  out  clog2(DEPTH)+1  number of pending stores

## Operation
- Storage: DEPTH entries of {addr, data}. Pointers head and tail are clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = (head[msb] != tail[msb]) && (low bits equal).
  - empty = (head == tail).
  - count = tail − head.
- Enqueue: at the edge where st_valid && st_ready, write the entry at tail and advance tail. A store offered while full is not accepted, even if a drain occurs in the same cycle. There is no pass-through.
- Match: compare ld_addr[AW-1:2] against addr[AW-1:2] of every occupied entry. The youngest match, closest to tail, wins. Only registered entries participate; a store enqueued in the same cycle is not visible to the load.
- Port arbitration, evaluated each cycle:
  1. ld_req && match (with STBUF_FWD_EN): ld_hit=1, ld_fwd_data = youngest match data. The port is free, so drain if !empty.
  2. ld_req && no match && !full: mem_re=1, mem_addr=ld_addr, mem_we=0. No drain this cycle.
  3. ld_req && no match && full: the drain takes the port and ld_stall=1. This guarantees forward progress.
  4. no ld_req: drain if !empty.
- Drain: mem_we=1, mem_addr and mem_wdata come from the head entry, and head advances at the edge.
- When idle, mem_addr = head entry addr (or 0 if empty), and mem_re = mem_we = 0.
- Simultaneous enqueue and drain: count is unchanged.
- ld_fwd_data = 0 whenever ld_hit=0.

## Timing
- Reset values, while reset is high and after release: head=tail=0, empty=1, count=0, st_ready=1.
- While reset is high, all strobes are held at 0: mem_we, mem_re, ld_hit, ld_stall. ld_fwd_data=0.
- Reset asserted mid-drain clears pending stores; they are discarded, not written.
- Store latency: a store accepted at edge N can produce its mem_we no earlier than the cycle after edge N.
- FIFO order is preserved: memory sees stores in acceptance order.
- Load forwarding and the miss read are combinational in the request cycle. There is zero added latency unless ld_stall is asserted.
- A stall lasts exactly one cycle per forced drain; the load retries the next cycle.

## Configuration
- STBUF_FWD_EN defined: forwarding as described.
- STBUF_FWD_EN undefined:
  - ld_hit is tied to 0 and ld_fwd_data to 0.
  - A load that matches any pending entry asserts ld_stall, and the drain takes the port.
  - The load repeats until no entry matches, then reads memory normally.
  - Match logic remains for stall detection.

## Test plan
- Reset, then store 0x10←0xAABBCCDD with no loads. Required: mem_we for one cycle the following cycle with mem_addr=0x10 and mem_wdata=0xAABBCCDD; then empty=1, count=0.
- Hold ld_req to address 0x100 while 4 stores are accepted (DEPTH=4). Required: st_ready=0 when count=4. Then one drain per cycle with ld_stall=1 (rule 3); after that drain st_ready=1 again and the next load to 0x100 asserts mem_re with no drain.
- Pending stores 0x20←1 then 0x20←2, then load 0x20 with FWD_EN. Required: ld_hit=1 and ld_fwd_data=2, mem_re=0, drain of head (data 1) in the same cycle.
- Same sequence without FWD_EN. Required: ld_stall=1 for 2 cycles while both entries drain in order (1 then 2); the third cycle gives mem_re=1 at mem_addr=0x20.
- Full buffer with st_valid high and a drain in the same cycle. Required: store not accepted, count drops to 3, store accepted on the next edge.
- Assert reset with 3 entries pending. Required: mem_we=0 immediately, and after release empty=1, count=0, with no writes to memory.
